// File: rtl/msrv32_fetch_unit.sv
// msrv32_fetch_unit: instruction fetch stage for the MSRV32 core.
// Issues word-aligned requests to instruction memory, presents one fetched
// instruction at a time, and handles branch and trap redirects, including
// draining a request that is already in flight when a trap arrives.
module msrv32_fetch_unit #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        branch_taken_in,
  input  logic [31:0] branch_target_in,
  input  logic        trap_taken_in,
  input  logic [31:0] trap_address_in,
  input  logic        stall_in,
  output logic        imreq_out,
  output logic [31:0] imaddr_out,
  input  logic        imack_in,
  input  logic [31:0] imdata_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid_out,
  output logic        flush_out,
  output logic        misaligned_instr_out
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    VALID     = 3'd2,
    KILL      = 3'd3,
    WAIT_TRAP = 3'd4
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] trap_target;
  logic [31:0] branch_target;
  logic [31:0] pc_seq;
  logic        trap_redirect;
  logic        trap_kill;

  assign trap_target   = {trap_address_in[31:2], 2'b00};
  assign branch_target = {branch_target_in[31:1], 1'b0};
  assign pc_seq        = pc + 32'd4;

  // Classify a trap: redirect now, or drain the in-flight request first.
  always_comb begin
    trap_redirect = 1'b0;
    trap_kill     = 1'b0;
    if (trap_taken_in) begin
      case (state)
        IDLE, VALID, WAIT_TRAP: trap_redirect = 1'b1;
        REQ, KILL: begin
          if (imack_in) begin
            trap_redirect = 1'b1;
          end else begin
            trap_kill = 1'b1;
          end
        end
        default: trap_redirect = 1'b0;
      endcase
    end else begin
      trap_redirect = 1'b0;
      trap_kill     = 1'b0;
    end
  end

  // Fetch state machine with all outputs registered alongside the state.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state                <= IDLE;
      pc                   <= BOOT_ADDRESS;
      instr_out            <= NOP_INSTR;
      pc_out               <= BOOT_ADDRESS;
      imreq_out            <= 1'b0;
      imaddr_out           <= BOOT_ADDRESS;
      instr_valid_out      <= 1'b0;
      flush_out            <= 1'b0;
      misaligned_instr_out <= 1'b0;
    end else if (trap_redirect) begin
      // Nothing outstanding (or its response arrives now and is dropped).
      state                <= REQ;
      pc                   <= trap_target;
      imreq_out            <= 1'b1;
      imaddr_out           <= trap_target;
      instr_valid_out      <= 1'b0;
      flush_out            <= 1'b1;
      misaligned_instr_out <= 1'b0;
    end else if (trap_kill) begin
      // Keep the old request on the bus until memory answers; remember target in pc.
      state                <= KILL;
      pc                   <= trap_target;
      imreq_out            <= 1'b1;
      instr_valid_out      <= 1'b0;
      flush_out            <= 1'b1;
      misaligned_instr_out <= 1'b0;
    end else begin
      flush_out <= 1'b0;
      case (state)
        IDLE: begin
          state                <= REQ;
          imreq_out            <= 1'b1;
          imaddr_out           <= pc;
          instr_valid_out      <= 1'b0;
          misaligned_instr_out <= 1'b0;
        end
        REQ: begin
          if (imack_in) begin
            state           <= VALID;
            instr_out       <= imdata_in;
            pc_out          <= pc;
            imreq_out       <= 1'b0;
            instr_valid_out <= 1'b1;
          end else begin
            imreq_out  <= 1'b1;
            imaddr_out <= pc;
          end
        end
        VALID: begin
          if (stall_in) begin
            instr_valid_out <= 1'b1;
          end else if (branch_taken_in) begin
            if (branch_target[1]) begin
              // Misaligned target: stop fetching and wait for the trap.
              state                <= WAIT_TRAP;
              instr_valid_out      <= 1'b0;
              misaligned_instr_out <= 1'b1;
            end else begin
              state           <= REQ;
              pc              <= branch_target;
              imreq_out       <= 1'b1;
              imaddr_out      <= branch_target;
              instr_valid_out <= 1'b0;
              flush_out       <= 1'b1;
            end
          end else begin
            state           <= REQ;
            pc              <= pc_seq;
            imreq_out       <= 1'b1;
            imaddr_out      <= pc_seq;
            instr_valid_out <= 1'b0;
          end
        end
        KILL: begin
          if (imack_in) begin
            // Stale response dropped; now fetch the latched trap target.
            state      <= REQ;
            imreq_out  <= 1'b1;
            imaddr_out <= pc;
          end else begin
            imreq_out <= 1'b1;
          end
        end
        WAIT_TRAP: begin
          imreq_out            <= 1'b0;
          instr_valid_out      <= 1'b0;
          misaligned_instr_out <= 1'b1;
        end
        default: begin
          state                <= IDLE;
          imreq_out            <= 1'b0;
          instr_valid_out      <= 1'b0;
          misaligned_instr_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
